// File: rtl/riscv_mem_pkg.sv
// Shared RV32I load/store definitions for the memory access unit: funct3 codes,
// FSM state encoding and the access legality rule.
package riscv_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_e;

    // Legal funct3 for the direction, and naturally aligned for its size.
    function automatic logic access_ok(input logic is_write, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_write;
            F3_HU:   ok = ~is_write & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/grant/rvalid memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    import riscv_mem_pkg::*;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [BE_W-1:0]   bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load extract/extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_off,
    input  logic [DATA_W-1:0] st_data,
    output logic [BE_W-1:0]   st_be,
    output logic [DATA_W-1:0] st_lanes,
    input  logic [2:0]        ld_f3,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] ld_raw,
    output logic [DATA_W-1:0] ld_ext
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Size code is funct3[1:0], so unsigned loads get the same lanes as signed ones.
    always_comb begin : store_steer
        st_be    = 4'b0000;
        st_lanes = st_data;
        case (st_size)
            2'b00: begin
                st_be    = 4'b0001 << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
            end
            2'b10:   st_be = 4'b1111;
            default: st_be = 4'b0000;
        endcase
    end

    always_comb begin : load_select
        ld_byte = ld_raw[7:0];
        case (ld_off)
            2'b00:   ld_byte = ld_raw[7:0];
            2'b01:   ld_byte = ld_raw[15:8];
            2'b10:   ld_byte = ld_raw[23:16];
            default: ld_byte = ld_raw[31:24];
        endcase
        ld_half = ld_off[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    always_comb begin : load_extend
        ld_ext = ld_raw;
        case (ld_f3)
            F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
            F3_BU:   ld_ext = {24'd0, ld_byte};
            F3_HU:   ld_ext = {16'd0, ld_half};
            default: ld_ext = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Turns controller MemRead/MemWrite strobes into a req/gnt/rvalid bus transaction.
// Optional bus timeout abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_unit
    import riscv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef MEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [2:0]          funct3,
    output logic                stall,
    output logic                done,
    output logic                err,
    output logic [DATA_W-1:0]   load_data,
    mem_access_unit_if.master   bus
);

    mem_state_e        state;
    logic [2:0]        lat_f3;
    logic [1:0]        lat_off;
    logic              strobe;
    logic              legal;
    logic              to_hit;
    logic [BE_W-1:0]   st_be;
    logic [DATA_W-1:0] st_lanes;
    logic [DATA_W-1:0] ld_ext;

    assign strobe = mem_read | mem_write;
    assign legal  = access_ok(mem_write, funct3, addr[1:0]);

    // Store lanes come from live inputs (captured in IDLE); loads use the latched access.
    mem_lane_align u_align (
        .st_size  (funct3[1:0]),
        .st_off   (addr[1:0]),
        .st_data  (wdata),
        .st_be    (st_be),
        .st_lanes (st_lanes),
        .ld_f3    (lat_f3),
        .ld_off   (lat_off),
        .ld_raw   (bus.bus_rdata),
        .ld_ext   (ld_ext)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
        end else if (state == ST_REQ || state == ST_WAIT_R) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Controller holds MEMREAD/MEMWRITE until the bus completes.
    assign stall = ((state == ST_IDLE) && strobe) || (state == ST_REQ) || (state == ST_WAIT_R);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            lat_f3        <= 3'b000;
            lat_off       <= 2'b00;
            done          <= 1'b0;
            err           <= 1'b0;
            load_data     <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (strobe) begin
                        lat_f3  <= funct3;
                        lat_off <= addr[1:0];
                        if (legal) begin
                            state         <= ST_REQ;
                            bus.bus_req   <= 1'b1;
                            bus.bus_we    <= mem_write;
                            bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus.bus_be    <= st_be;
                            bus.bus_wdata <= mem_write ? st_lanes : '0;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        if (bus.bus_we) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_WAIT_R;
                        end
                    end else if (to_hit) begin
                        bus.bus_req <= 1'b0;
                        state       <= ST_DONE;
                        done        <= 1'b1;
                        err         <= 1'b1;
                    end
                end
                ST_WAIT_R: begin
                    if (bus.bus_rvalid) begin
                        load_data <= ld_ext;
                        state     <= ST_DONE;
                        done      <= 1'b1;
                    end else if (to_hit) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        err   <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus random accesses
// against an arithmetic reference model. MEM_TIMEOUT_EN adds the timeout case.
module tb_mem_access_unit;
    import riscv_mem_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;

    int          total;
    int          bad;
    logic [31:0] exp_ld;

    mem_access_unit_if #(.ADDR_W(32)) bus_if ();

`ifdef MEM_TIMEOUT_EN
    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
`else
    mem_access_unit #(.ADDR_W(32)) dut (
`endif
        .clk       (clk),
        .reset_n   (reset_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .wdata     (wdata),
        .funct3    (funct3),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .load_data (load_data),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        if (we && f3 > 3'd2) return 1'b0;
        return (a % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] v;
        case (nbytes(f3))
            1:       v = (wd & 32'hFF) * 32'h0101_0101;
            2:       v = (wd & 32'hFFFF) * 32'h0001_0001;
            default: v = wd;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] m;
        logic [31:0] v;
        int          nb;
        nb = nbytes(f3);
        m  = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v  = (rd >> (8 * (a % 4))) & m;
        if (f3 < 3'd4 && nb < 4 && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    // One controller access; inputs driven and outputs sampled on falling edges.
    task automatic access(input logic we, input logic both, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input int gnt_dly, input int rv_dly, input logic [31:0] rd);
        logic ok;
        ok = model_legal(we, f3, a);
        @(negedge clk);
        mem_write = we;
        mem_read  = ~we | both;
        addr      = a;
        wdata     = wd;
        funct3    = f3;
        #1 chk("stall_idle_strobe", 32'(stall), 32'd1);
        @(negedge clk);
        if (!ok) begin
            chk("illegal_done_err", {30'd0, done, err}, 32'd3);
            chk("illegal_no_req", 32'(bus_if.bus_req), 32'd0);
            chk("illegal_ld_keep", load_data, exp_ld);
            chk("illegal_stall", 32'(stall), 32'd0);
            mem_write = 1'b0;
            mem_read  = 1'b0;
            return;
        end
        for (int k = 0; k <= gnt_dly; k++) begin
            chk("req_high", 32'(bus_if.bus_req), 32'd1);
            chk("req_stall", 32'(stall), 32'd1);
            chk("req_done", 32'(done), 32'd0);
            chk("req_we", 32'(bus_if.bus_we), 32'(we));
            chk("req_addr", bus_if.bus_addr, a & 32'hFFFF_FFFC);
            if (we) begin
                chk("req_be", 32'(bus_if.bus_be), 32'(model_be(f3, a)));
                chk("req_wdata", bus_if.bus_wdata, model_wdata(f3, wd));
            end
            bus_if.bus_gnt = (k == gnt_dly);
            @(negedge clk);
        end
        bus_if.bus_gnt = 1'b0;
        if (!we) begin
            for (int k = 0; k <= rv_dly; k++) begin
                chk("wait_req_low", 32'(bus_if.bus_req), 32'd0);
                chk("wait_stall", 32'(stall), 32'd1);
                chk("wait_done", 32'(done), 32'd0);
                bus_if.bus_rvalid = (k == rv_dly);
                bus_if.bus_rdata  = (k == rv_dly) ? rd : $urandom;
                @(negedge clk);
            end
            bus_if.bus_rvalid = 1'b0;
            exp_ld = model_load(f3, a, rd);
        end
        chk("done_pulse", {30'd0, done, err}, 32'd2);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req_low", 32'(bus_if.bus_req), 32'd0);
        chk("done_load_data", load_data, exp_ld);
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        total     = 0;
        bad       = 0;
        exp_ld    = 32'd0;
        reset_n   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 32'd0;
        wdata     = 32'd0;
        funct3    = 3'd0;
        bus_if.bus_gnt    = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = 32'd0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_outputs", {28'd0, stall, done, err, bus_if.bus_req}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
        reset_n = 1'b1;

        // Plan cases: SW, LB with waits, LHU, SH, misaligned LW, illegal funct3.
        access(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, F3_W, 0, 0, 32'd0);
        access(1'b0, 1'b0, 32'h203, 32'd0, F3_B, 3, 1, 32'h80FF_1234);
        chk("lb_value", load_data, 32'hFFFF_FF80);
        access(1'b0, 1'b0, 32'h202, 32'd0, F3_HU, 0, 0, 32'h8001_0000);
        chk("lhu_value", load_data, 32'h0000_8001);
        access(1'b1, 1'b0, 32'h106, 32'h0000_ABCD, F3_H, 1, 0, 32'd0);
        access(1'b0, 1'b0, 32'h102, 32'd0, F3_W, 0, 0, 32'd0);
        access(1'b0, 1'b0, 32'h100, 32'd0, 3'b011, 0, 0, 32'd0);
        access(1'b1, 1'b0, 32'h101, 32'h1234, F3_H, 0, 0, 32'd0);
        access(1'b1, 1'b0, 32'h100, 32'h1234, F3_BU, 0, 0, 32'd0);
        // Both strobes high: the write must win.
        access(1'b1, 1'b1, 32'h041, 32'h0000_005A, F3_B, 0, 0, 32'd0);

        repeat (60) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
            access(we, 1'b0, a, $urandom, f3, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // Reset while waiting for read data.
        @(negedge clk);
        mem_read = 1'b1;
        addr     = 32'h300;
        funct3   = F3_W;
        @(negedge clk);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        chk("pre_rst_stall", 32'(stall), 32'd1);
        reset_n  = 1'b0;
        mem_read = 1'b0;
        #1;
        chk("async_rst_req", 32'(bus_if.bus_req), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_ld", load_data, 32'd0);
        exp_ld = 32'd0;
        @(negedge clk);
        reset_n           = 1'b1;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        chk("late_rvalid_done", 32'(done), 32'd0);
        chk("late_rvalid_ld", load_data, 32'd0);
        chk("late_rvalid_req", 32'(bus_if.bus_req), 32'd0);
        access(1'b1, 1'b0, 32'h100, 32'hCAFE_F00D, F3_W, 0, 0, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Grant never comes: request held for 8 cycles, then an error completion.
        @(negedge clk);
        mem_write = 1'b1;
        addr      = 32'h180;
        wdata     = 32'h1111_2222;
        funct3    = F3_W;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("to_req_held", 32'(bus_if.bus_req), 32'd1);
            chk("to_no_done", 32'(done), 32'd0);
        end
        @(negedge clk);
        chk("to_req_drop", 32'(bus_if.bus_req), 32'd0);
        chk("to_done_err", {30'd0, done, err}, 32'd3);
        chk("to_ld_keep", load_data, exp_ld);
        mem_write = 1'b0;
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Downstream of the multicycle FSM controller; turns its MemRead/MemWrite/IorD memory strobes into a req/gnt/rvalid bus transaction.
- Steers byte lanes for RV32I loads and stores, and sign- or zero-extends load data.
- Asserts stall back to the controller so the MEMREAD/MEMWRITE state holds until the bus completes.
- Flags misaligned and illegal accesses without issuing a bus request.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32 and not user-overridable.
- TIMEOUT_CYCLES, 255, number of cycles in REQ/WAIT_R before abort; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- mem_read  in  1  load strobe from controller.
- mem_write  in  1  store strobe from controller.
- addr  in  ADDR_W  byte address (ALUOut when IorD=1).
- wdata  in  32  store data (rs2).
- funct3  in  3  access size/sign.
- stall  out  1  controller must hold its current state.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on misaligned/illegal access (or timeout when enabled).
- load_data  out  32  extended load result; stable until the next load completes.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-steered store data.
- bus_gnt  in  1  request accepted this cycle.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  32  read data.

Behaviour:
- Reset (async, reset_n=0): state=IDLE.
  - All outputs are 0, including load_data and bus_req; bus_req drops immediately.
  - A transaction in flight is abandoned; a late bus_gnt or bus_rvalid is ignored afterwards.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - Strobes and inputs are sampled. If mem_write, or mem_read, is high, latch addr, wdata, funct3 and the direction.
  - If both strobes are high, write wins.
  - A legal access goes to REQ. A misaligned/illegal access goes to DONE with the error flag set.
- REQ:
  - bus_req=1; bus_we/addr/be/wdata come from the latched values and are held stable until gnt.
  - On bus_gnt: write goes to DONE; read goes to WAIT_R.
- WAIT_R:
  - bus_req=0. On bus_rvalid, capture the extended data into load_data and go to DONE.
  - bus_rvalid outside WAIT_R is ignored.
- DONE:
  - done=1 and err=flag for exactly one cycle, then go to IDLE.
  - Strobes are not sampled in DONE.
- stall (combinational):
  - 1 when (IDLE and either strobe high), or state is REQ or WAIT_R.
  - 0 in DONE and in idle-without-strobe.
- Latency with zero-wait bus:
  - Write: capture at cycle 0, gnt at cycle 1, done at cycle 2.
  - Read: capture at cycle 0, gnt at cycle 1, rvalid at cycle 2, done at cycle 3.
- Store lanes:
  - SB (000): be = 4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH (001): be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated ×2.
  - SW (010): be = 4'b1111.
- Load extract:
  - Select the byte/half by addr[1:0].
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) passes through.
- Illegal or misaligned accesses:
  - funct3 011/110/111 are illegal.
  - Stores accept only 000/001/010.
  - A half access with addr[0]=1 is misaligned; a word access with addr[1:0]≠0 is misaligned.
  - Any of these: no bus_req, load_data is unchanged, err=done=1 in DONE.
- Back-to-back: a new strobe is accepted in the IDLE cycle that follows DONE.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+-bit counter is cleared on entering REQ and increments in REQ and WAIT_R.
  - On reaching TIMEOUT_CYCLES: drop bus_req, go to DONE with err=1, leave load_data unchanged.
- MEM_TIMEOUT_EN undefined: no counter; the unit waits indefinitely.

Decomposition:
- Shared package riscv_mem_pkg:
  - funct3 load/store localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State encoding for IDLE/REQ/WAIT_R/DONE.
- Sub-module mem_lane_align (combinational): store lane steering and be generation; load extract and extension.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt in first REQ cycle -> bus_be=4'b1111, bus_addr=0x100, done at cycle 2, stall high for cycles 0–1.
- LB addr=0x203, bus_rdata=0x80FF_1234, gnt after 3 wait cycles, rvalid 2 cycles later -> load_data=0xFFFFFF80, err=0, bus_req held throughout the wait.
- LHU addr=0x202, bus_rdata=0x8001_0000 -> load_data=0x00008001; SH addr=0x106, wdata=0x0000ABCD -> bus_be=4'b1100, bus_wdata=0xABCDABCD.
- LW addr=0x102 -> no bus_req, done=err=1 on cycle 1, load_data unchanged; same for funct3=3'b011.
- reset_n pulled low while in WAIT_R -> bus_req/done/load_data=0 immediately; a subsequent rvalid is ignored; the next SW completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus_gnt never asserted -> bus_req drops after 8 cycles, done=err=1.
